// File: rtl/bht_counter_update.sv
// Branch history table: 2-bit saturating counters with combinational lookup,
// execute-stage writeback, mispredict pulse and saturating statistics.
module bht_counter_update #(
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] lookup_idx,
    output logic [1:0]         n_taken_data,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken,
    input  logic               upd_pred,
    output logic               mispredict,
    output logic [CNT_W-1:0]   branch_cnt,
    output logic [CNT_W-1:0]   mispred_cnt
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [1:0]       bht_q [DEPTH];
    logic [1:0]       entry_d;
    logic             mispred_d;
    logic             mispred_q;
    logic [CNT_W-1:0] branch_d;
    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] mcnt_d;
    logic [CNT_W-1:0] mcnt_q;

    // Lookup sees pre-update state; no bypass from the write port.
    assign n_taken_data = bht_q[lookup_idx];

    always_comb begin
        entry_d = bht_q[upd_idx];
        if (upd_taken) begin
            if (bht_q[upd_idx] != 2'b11) entry_d = bht_q[upd_idx] + 2'd1;
        end else begin
            if (bht_q[upd_idx] != 2'b00) entry_d = bht_q[upd_idx] - 2'd1;
        end
    end

    always_comb begin
        mispred_d = upd_valid & (upd_taken ^ upd_pred);
        branch_d  = branch_q;
        mcnt_d    = mcnt_q;
        if (upd_valid && branch_q != {CNT_W{1'b1}}) begin
            branch_d = branch_q + 1'b1;
        end
        if (mispred_d && mcnt_q != {CNT_W{1'b1}}) begin
            mcnt_d = mcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
            mispred_q <= 1'b0;
            branch_q  <= '0;
            mcnt_q    <= '0;
        end else begin
            if (upd_valid) begin
                bht_q[upd_idx] <= entry_d;
            end
            mispred_q <= mispred_d;
            branch_q  <= branch_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign mispredict  = mispred_q;
    assign branch_cnt  = branch_q;
    assign mispred_cnt = mcnt_q;

endmodule

// File: tb/tb_bht_counter_update.sv
// Testbench for bht_counter_update: directed steps plus random traffic
// checked against an arithmetic reference model.
module tb_bht_counter_update;

    localparam int IW  = 4;
    localparam int CW  = 16;
    localparam int MAX = 65535;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] lookup_idx;
    logic [1:0]    n_taken_data;
    logic          upd_valid;
    logic [IW-1:0] upd_idx;
    logic          upd_taken;
    logic          upd_pred;
    logic          mispredict;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int mtab [16];
    int mbr;
    int mmis;
    int mmp;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bht_counter_update #(.INDEX_W(IW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (lookup_idx),
        .n_taken_data (n_taken_data),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_pred     (upd_pred),
        .mispredict   (mispredict),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: apply the rules to the inputs present before the edge.
    task automatic edge_step();
        if (!rst_n) begin
            foreach (mtab[i]) mtab[i] = 1;
            mbr  = 0;
            mmis = 0;
            mmp  = 0;
        end else begin
            mmp = (upd_valid && (upd_taken != upd_pred)) ? 1 : 0;
            if (upd_valid) begin
                if (upd_taken) mtab[upd_idx] = (mtab[upd_idx] < 3) ? mtab[upd_idx] + 1 : 3;
                else           mtab[upd_idx] = (mtab[upd_idx] > 0) ? mtab[upd_idx] - 1 : 0;
                mbr = (mbr < MAX) ? mbr + 1 : MAX;
                if (mmp == 1) mmis = (mmis < MAX) ? mmis + 1 : MAX;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_lk"}, 32'(n_taken_data), mtab[lookup_idx]);
        chk({tag, "_mp"}, 32'(mispredict), mmp);
        chk({tag, "_bc"}, 32'(branch_cnt), mbr);
        chk({tag, "_mc"}, 32'(mispred_cnt), mmis);
    endtask

    task automatic upd(input int idx, input bit tk, input bit pr, input string tag);
        upd_valid = 1'b1;
        upd_idx   = IW'(idx);
        upd_taken = tk;
        upd_pred  = pr;
        edge_step();
        upd_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            lookup_idx = IW'(i);
            #1;
            chk(tag, 32'(n_taken_data), 1);
        end
    endtask

    initial begin
        foreach (mtab[i]) mtab[i] = 0;
        mbr = 0; mmis = 0; mmp = 0;
        rst_n = 1'b0; upd_valid = 1'b0; upd_idx = '0;
        upd_taken = 1'b0; upd_pred = 1'b0; lookup_idx = '0;

        // Reset and sweep
        edge_step();
        rst_n = 1'b1;
        sweep("rst_sweep");
        chk("rst_bc", 32'(branch_cnt), 0);
        chk("rst_mc", 32'(mispred_cnt), 0);
        chk("rst_mp", 32'(mispredict), 0);

        // Index 3 climbs to strong taken
        lookup_idx = 4'd3;
        upd(3, 1, 0, "inc1");
        chk("inc1_v", 32'(n_taken_data), 2);
        chk("inc1_p", 32'(mispredict), 1);
        upd(3, 1, 0, "inc2");
        chk("inc2_v", 32'(n_taken_data), 3);
        chk("inc2_p", 32'(mispredict), 1);
        upd(3, 1, 1, "inc3");
        chk("inc3_v", 32'(n_taken_data), 3);
        chk("inc3_p", 32'(mispredict), 0);
        chk("inc3_bc", 32'(branch_cnt), 3);
        chk("inc3_mc", 32'(mispred_cnt), 2);

        // Index 3 falls to strong not-taken
        upd(3, 0, 0, "dec1");
        chk("dec1_v", 32'(n_taken_data), 2);
        upd(3, 0, 0, "dec2");
        chk("dec2_v", 32'(n_taken_data), 1);
        upd(3, 0, 0, "dec3");
        chk("dec3_v", 32'(n_taken_data), 0);
        upd(3, 0, 0, "dec4");
        chk("dec4_v", 32'(n_taken_data), 0);
        lookup_idx = 4'd4;
        #1;
        chk("idx4_hold", 32'(n_taken_data), 1);

        // Same-cycle read/write of index 5: no bypass
        lookup_idx = 4'd5;
        upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; upd_pred = 1'b1;
        #1;
        chk("rw5_old", 32'(n_taken_data), 1);
        edge_step();
        upd_valid = 1'b0;
        chk("rw5_new", 32'(n_taken_data), 2);
        check_all("rw5");

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            rst_n      = ($urandom_range(0, 39) != 0);
            upd_valid  = $urandom_range(0, 3) != 0;
            upd_idx    = IW'($urandom);
            upd_taken  = 1'($urandom);
            upd_pred   = 1'($urandom);
            lookup_idx = IW'($urandom);
            #1;
            chk("rnd_pre", 32'(n_taken_data), mtab[lookup_idx]);
            edge_step();
            rst_n = 1'b1;
            check_all("rnd");
        end
        upd_valid = 1'b0;

        // Saturation of both statistics
        rst_n = 1'b0;
        edge_step();
        rst_n = 1'b1;
        upd_valid = 1'b1;
        for (int n = 0; n < 65534; n++) begin
            upd_idx   = IW'(n);
            upd_taken = 1'($urandom);
            upd_pred  = ~upd_taken;
            edge_step();
        end
        upd_valid = 1'b0;
        check_all("pre_sat");
        chk("pre_sat_bc", 32'(branch_cnt), 32'hFFFE);
        for (int n = 0; n < 3; n++) begin
            upd(n, 1, 0, "sat");
            chk("sat_bc", 32'(branch_cnt), 32'hFFFF);
            chk("sat_mc", 32'(mispred_cnt), 32'hFFFF);
        end

        // Reset while a mispredicted update is presented
        upd(7, 1, 1, "pre_rst");
        rst_n = 1'b0;
        upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1; upd_pred = 1'b0;
        edge_step();
        rst_n = 1'b1;
        upd_valid = 1'b0;
        chk("rstupd_mp", 32'(mispredict), 0);
        chk("rstupd_bc", 32'(branch_cnt), 0);
        sweep("rstupd_sweep");
        edge_step();
        chk("rstupd_mp2", 32'(mispredict), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_counter_update.md
# bht_counter_update

Branch history table (BHT) owner: holds the per-index 2-bit saturating prediction counters, serves the counter value for the fetch-stage lookup, and writes counters back when a branch resolves in execute. It is the writer end of the `n_taken_data` path consumed by the branch predictor's `pcsrc_p` decision. It also flags mispredictions for pipeline flush and keeps saturating branch/mispredict statistics.

## Interface
Parameters:
- `INDEX_W`, 4: table index width; table depth is 2^INDEX_W entries.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `lookup_idx`  in  INDEX_W  fetch-stage table index (PC bits).
- `n_taken_data`  out  2  counter value at `lookup_idx`; combinational read.
- `upd_valid`  in  1  a resolved branch is presented this cycle.
- `upd_idx`  in  INDEX_W  table index of the resolving branch.
- `upd_taken`  in  1  actual outcome: 1 = taken.
- `upd_pred`  in  1  prediction (`pcsrc_p`) carried down the pipeline with this branch.
- `mispredict`  out  1  registered one-cycle pulse: the last update was mispredicted.
- `branch_cnt`  out  CNT_W  resolved branches since reset; saturating.
- `mispred_cnt`  out  CNT_W  mispredicted branches since reset; saturating.

## Operation
- Table: 2^INDEX_W entries of 2 bits. 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- Lookup: `n_taken_data = table[lookup_idx]`, purely combinational. It reflects state before any same-cycle update.
- Update: applies when `upd_valid`=1 at the clock edge. `table[upd_idx]` is written as follows:
  - `upd_taken`=1: increment, saturating at 11.
  - `upd_taken`=0: decrement, saturating at 00.
  - Only `upd_idx` is written. All other entries hold.
- `upd_valid`=0: no table, statistics, or mispredict change. `mispredict` returns to 0.
- Mispredict: on each edge, `mispredict <= upd_valid & (upd_taken ^ upd_pred)`.
- Statistics:
  - `branch_cnt` increments on each valid update.
  - `mispred_cnt` increments when a valid update is mispredicted.
  - Both saturate at all-ones and never wrap.
- `upd_pred` is trusted as given. The block does not recompute it from the table.
- Same index read and written in one cycle: the lookup returns the old value, and the new value is visible from the next cycle. There is no bypass.
- Reset (`rst_n`=0 at an edge):
  - Every table entry is set to 01.
  - `mispredict`, `branch_cnt` and `mispred_cnt` are set to 0.
  - Any update presented in the same cycle is dropped.
  - Reset takes effect mid-stream without ordering constraints.

## Timing
- Lookup latency is 0 cycles (combinational from `lookup_idx`).
- Update latency is 1 cycle: the written value appears on `n_taken_data` the cycle after the edge that captures `upd_valid`.
- `mispredict` is high for exactly the one cycle after a mispredicted valid update. Back-to-back mispredicted updates hold it high continuously.
- Updates are accepted every cycle; there is no handshake and no stall output.
- The counter values `branch_cnt` and `mispred_cnt` are updated at the same edge as the table write.

## Test plan
- Reset with `rst_n`=0 for 1 cycle, then sweep `lookup_idx` 0..15: every read returns 01, both statistics read 0, `mispredict`=0.
- Index 3, three taken updates with `upd_pred`=0,0,1: the entry goes 01→10→11→11; `mispredict` pulses 1,1,0; `branch_cnt`=3, `mispred_cnt`=2.
- Index 3 from 11, four not-taken updates: 10,01,00,00. Index 4 stays 01 throughout.
- `lookup_idx`=5 and an update to index 5 (taken) in the same cycle: the lookup returns 01 that cycle and 10 the next cycle.
- Preload `branch_cnt` to 0xFFFE via 65534 updates, then 3 more: the counter holds at 0xFFFF.
- Assert `rst_n`=0 while `upd_valid`=1 with a mispredict: the update is dropped, the table is all 01, and `mispredict`=0 on the next cycle.
